// File: rtl/fifo_rd_stream_pkg.sv
// Shared sizing helpers and constants for the fifo_rd_stream read adapter.
package fifo_rd_stream_pkg;

  localparam int STATS_CNT_W = 32;

  // The two spare slots absorb the words still in flight when the consumer stalls.
  function automatic int buf_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Circular landing buffer for fifo_rd_stream: storage, write/read indices and occupancy.
module fifo_rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3,
  parameter int OCC_W      = occ_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occ,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]      r_wr_idx;
  logic [IDX_W-1:0]      r_rd_idx;
  logic [OCC_W-1:0]      r_occ;

  // Storage is reset so the output word reads as zero straight out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_idx <= '0;
    end else if (push) begin
      r_mem[r_wr_idx] <= push_data;
      r_wr_idx        <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_idx <= '0;
    end else if (pop) begin
      r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_occ <= '0;
    end else begin
      case ({push, pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occ   = r_occ;
  assign valid = (r_occ != '0);
  assign data  = r_mem[r_rd_idx];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a non-FWFT synchronous FIFO into a valid/ready stream using a read credit scheme.
// Optional statistics counters are built when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  output logic                   fifo_rd_en,
  output logic                   m_tvalid,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  input  logic                   m_tready
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0] beat_cnt,
  output logic [STATS_CNT_W-1:0] stall_cnt
`endif
);

  localparam int BUF_DEPTH = buf_depth(RD_LAT);
  localparam int OCC_W     = occ_width(BUF_DEPTH);
  localparam int SUM_W     = OCC_W + 2;

  logic [RD_LAT-1:0] r_rd_pipe;
  logic [OCC_W-1:0]  w_occ;
  logic [SUM_W-1:0]  w_inflight;
  logic              w_credit_ok;
  logic              w_push;
  logic              w_pop;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + SUM_W'(r_rd_pipe[i]);
    end
  end

  // Credit counts words already landed plus words still travelling through the FIFO read port,
  // so a returning word always finds a free slot and m_tready never reaches the read strobe.
  assign w_credit_ok = (SUM_W'(w_occ) + w_inflight) < SUM_W'(BUF_DEPTH);
  assign fifo_rd_en  = ~fifo_empty & w_credit_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end
  end

  assign w_push = r_rd_pipe[RD_LAT-1];
  assign w_pop  = m_tvalid & m_tready;

  fifo_rd_stream_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUF_DEPTH),
    .OCC_W     (OCC_W)
  ) u_buf (
    .clk      (clk),
    .resetn   (resetn),
    .push     (w_push),
    .push_data(fifo_dout),
    .pop      (w_pop),
    .occ      (w_occ),
    .valid    (m_tvalid),
    .data     (m_tdata)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STATS_CNT_W-1:0] r_beat_cnt;
  logic [STATS_CNT_W-1:0] r_stall_cnt;

  // Beats wrap naturally; stall cycles pin at all-ones so a long stall never reads as short.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + STATS_CNT_W'(1);
      end
      if (m_tvalid && !m_tready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STATS_CNT_W'(1);
      end
    end
  end

  assign beat_cnt  = r_beat_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: behavioural FIFO with read latency, queue-based expectations.
module tb_fifo_rd_stream;

  localparam int DW        = 8;
  localparam int RD_LAT    = 2;
  localparam int BUF_DEPTH = RD_LAT + 2;
  localparam int MEM_N     = 4096;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tready = 1'b0;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]   beat_cnt;
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tready  (m_tready)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural FIFO: a read pops the head and the word emerges RD_LAT cycles later.
  logic [DW-1:0] fmem [MEM_N];
  int            wptr = 0;
  int            rptr = 0;
  int            rd_total = 0;
  logic [DW-1:0] dpipe [RD_LAT] = '{default: '0};

  assign fifo_empty = (wptr == rptr);
  assign fifo_dout  = dpipe[RD_LAT-1];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr     <= wptr;
      rd_total <= 0;
      for (int i = 0; i < RD_LAT; i++) dpipe[i] <= '0;
    end else begin
      if (fifo_rd_en && (rptr != wptr)) begin
        dpipe[0] <= fmem[rptr % MEM_N];
        rptr     <= rptr + 1;
        rd_total <= rd_total + 1;
      end else begin
        dpipe[0] <= DW'($urandom);
      end
      for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  end

  logic [DW-1:0] exp_q [$];

  task automatic push_word(input logic [DW-1:0] w);
    fmem[wptr % MEM_N] = w;
    wptr++;
    exp_q.push_back(w);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each accepted beat.
  int            beats = 0;
  int            pop_total = 0;
  logic [31:0]   beat_model = 0;
  logic [31:0]   stall_model = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      pop_total   = 0;
      beat_model  = 0;
      stall_model = 0;
      prev_hold   = 1'b0;
    end else begin
      chk("no_underflow", 32'(fifo_rd_en && fifo_empty), 32'd0);
      chk("credit_bound", 32'((rd_total - pop_total) <= BUF_DEPTH && (rd_total - pop_total) >= 0), 32'd1);
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("beat_cnt", beat_cnt, beat_model);
      chk("stall_cnt", stall_cnt, stall_model);
`endif
      if (prev_hold) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        chk("hold_data", 32'(m_tdata), 32'(prev_data));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(m_tdata), 32'hFFFF_FFFF);
        end else begin
          chk("beat_data", 32'(m_tdata), 32'(exp_q.pop_front()));
        end
        pop_total++;
        beats++;
        beat_model++;
      end
      if (m_tvalid && !m_tready && stall_model != 32'hFFFF_FFFF) stall_model++;
      prev_hold = m_tvalid && !m_tready;
      prev_data = m_tdata;
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      m_tready = 1'b1;
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_rd, t_v, t_last, nb, r0, b0, loaded;

    resetn   = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset then idle
    repeat (20) begin
      @(negedge clk);
      chk("idle_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("idle_tvalid", 32'(m_tvalid), 32'd0);
      chk("idle_tdata", 32'(m_tdata), 32'd0);
    end

    // Streaming: latency RD_LAT+1, then back-to-back beats
    @(posedge clk); #1;
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(DW'(i));
    t_rd = -1; t_v = -1; t_last = -1; nb = 0;
    for (int n = 0; n < 100 && nb < 16; n++) begin
      @(negedge clk);
      if (fifo_rd_en && t_rd < 0) t_rd = cyc;
      if (m_tvalid && t_v < 0) t_v = cyc;
      if (m_tvalid && m_tready) begin nb++; t_last = cyc; end
    end
    chk("stream_latency", 32'(t_v - t_rd), 32'(RD_LAT + 1));
    chk("stream_beats", 32'(nb), 32'd16);
    chk("stream_back_to_back", 32'(t_last - t_v), 32'd15);

    // Full backpressure
    @(posedge clk); #1;
    m_tready = 1'b0;
    r0 = rd_total;
    for (int i = 0; i < 16; i++) push_word(DW'(i));
    repeat (20) @(negedge clk);
    chk("bp_reads", 32'(rd_total - r0), 32'(BUF_DEPTH));
    chk("bp_tvalid", 32'(m_tvalid), 32'd1);
    chk("bp_tdata", 32'(m_tdata), 32'h00);
    chk("bp_rd_en_low", 32'(fifo_rd_en), 32'd0);
    @(posedge clk); #1;
    m_tready = 1'b1;
    @(negedge clk);
    chk("release_rd_en_same", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    chk("release_rd_en_next", 32'(fifo_rd_en), 32'd1);
    wait_drain("bp_drain", 200);

    // Drain with one word in flight when the FIFO goes empty
    repeat (5) @(posedge clk); #1;
    r0 = rd_total; b0 = beats;
    push_word(8'h5A);
    repeat (15) @(negedge clk);
    chk("drain_reads", 32'(rd_total - r0), 32'd1);
    chk("drain_beats", 32'(beats - b0), 32'd1);
    chk("drain_tvalid", 32'(m_tvalid), 32'd0);

    // Random ready with bursty loading
    b0 = beats; loaded = 0;
    while (loaded < 1000) begin
      @(posedge clk); #1;
      m_tready = 1'($urandom % 2);
      if (($urandom % 3) != 0) begin
        push_word(DW'($urandom));
        loaded++;
      end
    end
    for (int n = 0; n < 5000 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
      m_tready = 1'($urandom % 2);
    end
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    chk("rand_beats", 32'(beats - b0), 32'd1000);

    // Reset mid-stream with a partly full buffer
    @(posedge clk); #1;
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(DW'(8'h30 + i));
    repeat (10) @(negedge clk);
    chk("pre_reset_tvalid", 32'(m_tvalid), 32'd1);
    #2 resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("rst_beat_cnt", beat_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    b0 = beats;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(DW'(8'hA0 + i));
    wait_drain("post_reset_drain", 100);
    repeat (5) @(negedge clk);
    chk("post_reset_beats", 32'(beats - b0), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter that drains a standard (non-FWFT) synchronous FIFO and presents its contents as a valid/ready stream. It issues `fifo_rd_en` on the FIFO's read port, tracks reads in flight across the FIFO's fixed read latency, and lands the returned words in a small output buffer. It sits between any `fifo_sync` instance (FWFT=0) and a downstream consumer that applies backpressure. It guarantees no FIFO underflow and no lost words, and has no combinational path from `m_tready` to `fifo_rd_en`.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width.
- `RD_LAT`, 1: FIFO read latency in cycles, from `fifo_rd_en` to data on `fifo_dout`. Legal values are 1..3.

Ports:
- `clk`, in, 1: single clock for all logic.
- `resetn`, in, 1: asynchronous, active-low reset.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_dout`, in, DATA_WIDTH: FIFO read data, valid RD_LAT cycles after `fifo_rd_en`.
- `fifo_rd_en`, out, 1: FIFO read strobe.
- `m_tvalid`, out, 1: output word valid.
- `m_tdata`, out, DATA_WIDTH: output word.
- `m_tready`, in, 1: consumer accepts the word.
- `beat_cnt`, out, 32: accepted-beat count. Present only with `FIFO_RD_STREAM_STATS_EN`.
- `stall_cnt`, out, 32: backpressure cycle count. Present only with `FIFO_RD_STREAM_STATS_EN`.

## Operation
- `BUF_DEPTH` = RD_LAT+2. The output buffer is circular, with a write index, a read index and an occupancy counter `occ` (0..BUF_DEPTH).
- `inflight` = number of set bits in an RD_LAT-stage shift register `rd_pipe`. `rd_pipe[0]` is loaded with `fifo_rd_en` each cycle.
- `fifo_rd_en` = `~fifo_empty & (occ + inflight < BUF_DEPTH)`. It uses registered state plus `fifo_empty` only and never depends on `m_tready`.
- When `rd_pipe[RD_LAT-1]` is set, `fifo_dout` is written to `buf[wr_idx]` and `wr_idx` advances.
- `m_tvalid` = `(occ != 0)`. `m_tdata` = `buf[rd_idx]`.
- A pop is `m_tvalid & m_tready`; on a pop, `rd_idx` advances.
- Both indices wrap from BUF_DEPTH-1 to 0.
- Occupancy update:
  - push only: `occ+1`.
  - pop only: `occ-1`.
  - push and pop in the same cycle: `occ` unchanged. Both indices advance.
- The credit rule guarantees a push never finds the buffer full. `occ` never exceeds BUF_DEPTH.
- `m_tdata` must hold stable while `m_tvalid & ~m_tready`.
- Words leave in FIFO order. No word is dropped or duplicated.
- If `fifo_empty` rises while reads are in flight, the in-flight words are still captured. No further `fifo_rd_en` is issued.
- The block has no state machine. All behaviour is the credit counter plus the buffer.

## Timing
- Reset values: `fifo_rd_en`=0, `m_tvalid`=0, `m_tdata`=0, `occ`=0, indices=0, `rd_pipe`=0, counters=0.
- A reset asserted mid-operation discards buffered and in-flight words. The FIFO's own reset is expected to be shared.
- Latency: `fifo_rd_en` in cycle t → buffer write at the end of t+RD_LAT → `m_tvalid` high in t+RD_LAT+1.
- Throughput: with `m_tready` held high and the FIFO non-empty, one word per cycle sustained after the initial latency.
- Backpressure: with `m_tready` low, at most BUF_DEPTH words are accepted from the FIFO, then `fifo_rd_en` stays low.
- On `m_tready` returning high, the first pop happens that cycle. `fifo_rd_en` re-asserts the next cycle.

## Configuration
- `FIFO_RD_STREAM_STATS_EN` defined: adds `beat_cnt` and `stall_cnt`.
  - `beat_cnt` increments on every pop and wraps at 2^32.
  - `stall_cnt` increments each cycle with `m_tvalid & ~m_tready` and saturates at 0xFFFF_FFFF.
  - Both are cleared only by reset.
- Macro undefined: neither port nor counter exists. Datapath behaviour is identical.

## Structure
- Package `fifo_rd_stream_pkg` holds:
  - function `buf_depth(rd_lat)`.
  - function `occ_width(depth)` = `$clog2(depth+1)`.
  - constant `STATS_CNT_W` = 32.
- Sub-module `fifo_rd_stream_buf` is the circular buffer: indices, occupancy, storage, push and pop ports, and `occ` output.
- The top level holds `rd_pipe`, the credit compare, and the stats counters.

## Test plan
- **Reset then idle:** hold `fifo_empty`=1 for 20 cycles → `fifo_rd_en`, `m_tvalid`, `m_tdata` and `occ` stay 0.
- **Streaming:** RD_LAT=1, 16 words 0x00..0x0F preloaded, `m_tready`=1 → `m_tvalid` first high 2 cycles after the first `fifo_rd_en`; 16 consecutive beats in order; `beat_cnt`=16 with stats enabled.
- **Full backpressure:** 16 words loaded, `m_tready`=0 → exactly 3 `fifo_rd_en` pulses; `m_tdata`=0x00 held stable; `stall_cnt` increments every cycle.
- **Random `m_tready`:** 50% random `m_tready` over 1000 words, RD_LAT=2 → output matches the input sequence; `occ` never exceeds 4; the FIFO underflow flag never asserts.
- **Drain with in-flight reads:** FIFO holds 1 word and `fifo_empty` rises the cycle after `fifo_rd_en` → exactly 1 output beat, then `m_tvalid`=0.
- **Reset mid-stream:** `resetn` pulsed low with `occ`=3 → all outputs return to 0 asynchronously; after release, streaming resumes from the new FIFO contents.
